usb_rx_deserializer: RTL

USB_RX_DESERIALIZER -- requirements
Module: usb_rx_deserializer

---
 rtl/usb_phy_pkg.sv | 38 +++
 rtl/usb_bit_unstuffer.sv | 57 +++++
 rtl/usb_rx_deserializer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/usb_phy_pkg.sv
// ============================================================================
// Module      : usb_phy_pkg
// Description : Shared line encodings, receive FSM states and error codes
//               for the USB full-speed receive path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package usb_phy_pkg;

    typedef enum logic [1:0] {
        LINE_ILLEGAL = 2'b00,
        LINE_J       = 2'b01,
        LINE_K       = 2'b10,
        LINE_SE0     = 2'b11
    } line_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_ERR  = 2'd2
    } rx_state_t;

    typedef enum logic [1:0] {
        ERR_STUFF   = 2'd0,
        ERR_ALIGN   = 2'd1,
        ERR_ILLEGAL = 2'd2,
        ERR_ABORT   = 2'd3
    } rx_err_t;

    // The last sync bit is a 1, so a fresh packet starts with one 1 counted.
    localparam logic [2:0]  c_ones_init    = 3'd1;
    localparam logic [2:0]  c_ones_max     = 3'd6;
    localparam logic [10:0] c_byte_cnt_max = 11'd2047;

endpackage

`default_nettype wire

// File: rtl/usb_bit_unstuffer.sv
// ============================================================================
// Module      : usb_bit_unstuffer
// Description : NRZI decoder with bit-unstuffing; flags stuff bits and
//               stuffing violations for the current J/K sample.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_bit_unstuffer
    import usb_phy_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_start,
    input  logic       i_en,
    input  logic [1:0] i_level,
    output logic       o_bit,
    output logic       o_bit_valid,
    output logic       o_stuff_err
);

    logic [1:0] r_prev;
    logic [2:0] r_ones;
    logic [1:0] w_prev;
    logic [2:0] w_ones;
    logic       w_bit;
    logic       w_at_limit;

    // On the packet's first sample the history is taken from the sync pattern.
    always_comb begin
        w_prev     = i_start ? LINE_K : r_prev;
        w_ones     = i_start ? c_ones_init : r_ones;
        w_bit      = (i_level == w_prev);
        w_at_limit = (w_ones == c_ones_max);
    end

    assign o_bit       = w_bit;
    assign o_bit_valid = i_en && !w_at_limit;
    assign o_stuff_err = i_en && w_at_limit && w_bit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev <= LINE_K;
            r_ones <= '0;
        end else if (i_en) begin
            r_prev <= i_level;
            if (w_at_limit || !w_bit) begin
                r_ones <= '0;
            end else begin
                r_ones <= w_ones + 3'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/usb_rx_deserializer.sv
// ============================================================================
// Module      : usb_rx_deserializer
// Description : USB receive deserializer: assembles unstuffed bits into bytes
//               and reports end-of-packet and packet errors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_rx_deserializer
    import usb_phy_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  line_state,
    input  logic        sync_detected,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_active,
    output logic        rx_eop,
    output logic        rx_error,
    output logic [1:0]  rx_err_code,
    output logic [10:0] rx_byte_cnt
);

    rx_state_t   r_state, w_state_nxt;
    rx_err_t     r_err_code, w_err_code_nxt;
    logic [6:0]  r_shift, w_shift_nxt;
    logic [2:0]  r_bit_cnt, w_bit_cnt_nxt, w_bit_cnt_cur;
    logic [7:0]  r_data, w_data_nxt;
    logic [10:0] r_byte_cnt, w_byte_cnt_nxt, w_byte_cnt_cur;
    logic        r_valid, w_valid_nxt;
    logic        r_eop, w_eop_nxt;
    logic        r_error, w_error_nxt;
    logic        r_active;
    logic [7:0]  w_shifted;
    logic        w_start, w_recv_edge, w_line_jk;
    logic        w_bit, w_bit_valid, w_stuff_err;

    assign w_start     = (r_state == ST_IDLE) && sync_detected;
    assign w_recv_edge = (r_state == ST_RECV) || w_start;
    assign w_line_jk   = (line_state == LINE_J) || (line_state == LINE_K);

    usb_bit_unstuffer u_unstuffer (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_start     (w_start),
        .i_en        (w_recv_edge && w_line_jk),
        .i_level     (line_state),
        .o_bit       (w_bit),
        .o_bit_valid (w_bit_valid),
        .o_stuff_err (w_stuff_err)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_err_code_nxt = r_err_code;
        w_shift_nxt    = r_shift;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_data_nxt     = r_data;
        w_byte_cnt_nxt = r_byte_cnt;
        w_valid_nxt    = 1'b0;
        w_eop_nxt      = 1'b0;
        w_error_nxt    = 1'b0;
        w_bit_cnt_cur  = w_start ? 3'd0 : r_bit_cnt;
        w_byte_cnt_cur = w_start ? 11'd0 : r_byte_cnt;
        w_shifted      = {w_bit, r_shift};

        if (r_state == ST_ERR && !sync_detected) begin
            w_state_nxt = ST_IDLE;
        end

        // Error checks are ordered so an error always pre-empts a byte completion.
        if (w_recv_edge) begin
            w_state_nxt    = ST_RECV;
            w_bit_cnt_nxt  = w_bit_cnt_cur;
            w_byte_cnt_nxt = w_byte_cnt_cur;
            if (!sync_detected && line_state != LINE_SE0) begin
                w_state_nxt    = ST_ERR;
                w_error_nxt    = 1'b1;
                w_err_code_nxt = ERR_ABORT;
            end else if (line_state == LINE_SE0) begin
                w_state_nxt = ST_IDLE;
                if (w_bit_cnt_cur == 3'd0) begin
                    w_eop_nxt = 1'b1;
                end else begin
                    w_error_nxt    = 1'b1;
                    w_err_code_nxt = ERR_ALIGN;
                end
            end else if (line_state == LINE_ILLEGAL) begin
                w_state_nxt    = ST_ERR;
                w_error_nxt    = 1'b1;
                w_err_code_nxt = ERR_ILLEGAL;
            end else if (w_stuff_err) begin
                w_state_nxt    = ST_ERR;
                w_error_nxt    = 1'b1;
                w_err_code_nxt = ERR_STUFF;
            end else if (w_bit_valid) begin
                w_shift_nxt   = w_shifted[7:1];
                w_bit_cnt_nxt = w_bit_cnt_cur + 3'd1;
                if (w_bit_cnt_cur == 3'd7) begin
                    w_data_nxt  = w_shifted;
                    w_valid_nxt = 1'b1;
                    if (w_byte_cnt_cur != c_byte_cnt_max) begin
                        w_byte_cnt_nxt = w_byte_cnt_cur + 11'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_err_code <= ERR_STUFF;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_data     <= '0;
            r_byte_cnt <= '0;
            r_valid    <= 1'b0;
            r_eop      <= 1'b0;
            r_error    <= 1'b0;
            r_active   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_err_code <= w_err_code_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_data     <= w_data_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_valid    <= w_valid_nxt;
            r_eop      <= w_eop_nxt;
            r_error    <= w_error_nxt;
            r_active   <= (w_state_nxt == ST_RECV);
        end
    end

    assign rx_data     = r_data;
    assign rx_valid    = r_valid;
    assign rx_active   = r_active;
    assign rx_eop      = r_eop;
    assign rx_error    = r_error;
    assign rx_err_code = r_err_code;
    assign rx_byte_cnt = r_byte_cnt;

endmodule

`default_nettype wire
